// File: rtl/exec_controller_pkg.sv
// Shared definitions for the run/halt/single-step sequencer.
//   - default widths for PC, instruction and cycle counter
//   - sequencer state encoding and halt cause codes
//   - ECALL / EBREAK instruction words
package exec_controller_pkg;

   localparam int XLEN_DEF  = 64;
   localparam int ILEN_DEF  = 32;
   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      CAUSE_NONE   = 3'd0,
      CAUSE_HOST   = 3'd1,
      CAUSE_BP     = 3'd2,
      CAUSE_LIMIT  = 3'd3,
      CAUSE_ECALL  = 3'd4,
      CAUSE_EBREAK = 3'd5,
      CAUSE_STEP   = 3'd6
   } cause_e;

   localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/exec_controller_halt_detect.sv
// Combinational halt priority encoder.
// Inputs : state, skip (resume-past-breakpoint flag), halt_req, bp_match,
//          limit_match, instruction.
// Outputs: halt_fire (go to HALTED at next edge), commit_ok (datapath may
//          update this cycle), cause (halt reason, valid when halt_fire).
module exec_controller_halt_detect
   import exec_controller_pkg::*;
#(
   parameter int ILEN = ILEN_DEF
) (
   input  state_e            state,
   input  logic              skip,
   input  logic              halt_req,
   input  logic              bp_match,
   input  logic              limit_match,
   input  logic [ILEN-1:0]   instruction,
   output logic              halt_fire,
   output logic              commit_ok,
   output cause_e            cause
);

   logic is_ecall_s;
   logic is_ebreak_s;

   assign is_ecall_s  = (instruction == ILEN'(INSN_ECALL));
   assign is_ebreak_s = (instruction == ILEN'(INSN_EBREAK));

   // Priority encode the halt reason for the current cycle.
   always_comb begin
      halt_fire = 1'b0;
      commit_ok = 1'b0;
      cause     = CAUSE_NONE;
      case (state)
         ST_RUN: begin
            if (halt_req) begin
               halt_fire = 1'b1;
               cause     = CAUSE_HOST;
            end else if (bp_match && !skip) begin
               halt_fire = 1'b1;
               cause     = CAUSE_BP;
            end else if (limit_match) begin
               halt_fire = 1'b1;
               cause     = CAUSE_LIMIT;
            end else if (is_ecall_s) begin
               // ECALL/EBREAK retire before halting
               halt_fire = 1'b1;
               commit_ok = 1'b1;
               cause     = CAUSE_ECALL;
            end else if (is_ebreak_s) begin
               halt_fire = 1'b1;
               commit_ok = 1'b1;
               cause     = CAUSE_EBREAK;
            end else begin
               commit_ok = 1'b1;
            end
         end
         ST_STEP: begin
            // A step always ends in HALTED; breakpoint and limit are ignored.
            halt_fire = 1'b1;
            if (halt_req) begin
               cause = CAUSE_HOST;
            end else if (is_ecall_s) begin
               commit_ok = 1'b1;
               cause     = CAUSE_ECALL;
            end else if (is_ebreak_s) begin
               commit_ok = 1'b1;
               cause     = CAUSE_EBREAK;
            end else begin
               commit_ok = 1'b1;
               cause     = CAUSE_STEP;
            end
         end
         default: begin
            halt_fire = 1'b0;
            commit_ok = 1'b0;
            cause     = CAUSE_NONE;
         end
      endcase
   end

endmodule

// File: rtl/exec_controller.sv
// Run/halt/single-step sequencer for the single-cycle RISC-V datapath.
// Inputs : clk, reset (async active-low), start/step pulses, halt_req level,
//          breakpoint enable/address, max_cycles limit (0 = unlimited),
//          current pc and instruction.
// Outputs: commit_en (gates all architectural updates), running, halted,
//          halt_cause, retired_count, cycle_count.
module exec_controller
   import exec_controller_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int ILEN  = ILEN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              step,
   input  logic              halt_req,
   input  logic              bp_en,
   input  logic [XLEN-1:0]   bp_addr,
   input  logic [CNT_W-1:0]  max_cycles,
   input  logic [XLEN-1:0]   pc,
   input  logic [ILEN-1:0]   instruction,
   output logic              commit_en,
   output logic              running,
   output logic              halted,
   output logic [2:0]        halt_cause,
   output logic [63:0]       retired_count,
   output logic [CNT_W-1:0]  cycle_count
);

   // Saturating increment of the cycle counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   state_e            state_q, state_d;
   logic              skip_q, skip_d;
   logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
   logic [63:0]       retired_count_q, retired_count_d;
   cause_e            halt_cause_q, halt_cause_d;

   logic              idle_like_s;
   logic              enter_run_s;
   logic              enter_step_s;
   logic              bp_match_s;
   logic              limit_match_s;
   logic              halt_fire_s;
   logic              commit_ok_s;
   cause_e            cause_s;

   assign idle_like_s   = (state_q == ST_IDLE) || (state_q == ST_HALTED);
   assign enter_run_s   = idle_like_s && start;
   assign enter_step_s  = idle_like_s && !start && step;
   assign bp_match_s    = bp_en && (pc == bp_addr);
   assign limit_match_s = (max_cycles != {CNT_W{1'b0}}) && (cycle_count_q == max_cycles);

   exec_controller_halt_detect #(.ILEN(ILEN)) u_halt_detect (
      .state       (state_q),
      .skip        (skip_q),
      .halt_req    (halt_req),
      .bp_match    (bp_match_s),
      .limit_match (limit_match_s),
      .instruction (instruction),
      .halt_fire   (halt_fire_s),
      .commit_ok   (commit_ok_s),
      .cause       (cause_s)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start has priority over step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (enter_run_s) begin
               state_d = ST_RUN;
            end else if (enter_step_s) begin
               state_d = ST_STEP;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN, ST_STEP: begin
            if (halt_fire_s) begin
               state_d = ST_HALTED;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the registered state.
   always_comb begin
      commit_en = commit_ok_s;
      running   = (state_q == ST_RUN) || (state_q == ST_STEP);
      halted    = (state_q == ST_HALTED);
   end

   // Next values of skip flag, counters and latched cause.
   always_comb begin
      // skip lets the first instruction after a resume pass a breakpoint
      if (enter_run_s || enter_step_s) begin
         skip_d = 1'b1;
      end else if (commit_ok_s) begin
         skip_d = 1'b0;
      end else begin
         skip_d = skip_q;
      end

      if (enter_run_s) begin
         cycle_count_d = {CNT_W{1'b0}};
      end else if ((state_q == ST_RUN) && !halt_fire_s) begin
         cycle_count_d = sat_inc(cycle_count_q);
      end else begin
         cycle_count_d = cycle_count_q;
      end

      if (commit_ok_s) begin
         retired_count_d = retired_count_q + 64'd1;
      end else begin
         retired_count_d = retired_count_q;
      end

      if (halt_fire_s) begin
         halt_cause_d = cause_s;
      end else begin
         halt_cause_d = halt_cause_q;
      end
   end

   // Skip flag, counter and cause registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skip_q          <= 1'b0;
         cycle_count_q   <= {CNT_W{1'b0}};
         retired_count_q <= 64'd0;
         halt_cause_q    <= CAUSE_NONE;
      end else begin
         skip_q          <= skip_d;
         cycle_count_q   <= cycle_count_d;
         retired_count_q <= retired_count_d;
         halt_cause_q    <= halt_cause_d;
      end
   end

   assign halt_cause    = halt_cause_q;
   assign retired_count = retired_count_q;
   assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_exec_controller.sv
// Scoreboard bench for exec_controller: tests push expected commit PCs and
// expected halt snapshots; a negedge monitor pops and compares them whenever
// the DUT commits or enters HALTED.
module tb_exec_controller;

   typedef struct {
      logic [2:0]  cause;
      logic [63:0] retired;
      logic [31:0] cyc;
   } halt_exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, step, halt_req, bp_en;
   logic [63:0] bp_addr;
   logic [31:0] max_cycles;
   logic [63:0] pc;
   logic [31:0] instruction;
   logic        commit_en, running, halted;
   logic [2:0]  halt_cause;
   logic [63:0] retired_count;
   logic [31:0] cycle_count;

   logic [31:0] imem [0:15];
   logic [63:0] pcq [$];
   halt_exp_t   hq  [$];
   logic        halted_prev;
   int          checks = 0;
   int          errors = 0;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   always #5 clk = ~clk;

   exec_controller dut (
      .clk           (clk),
      .reset         (rst_n),
      .start         (start),
      .step          (step),
      .halt_req      (halt_req),
      .bp_en         (bp_en),
      .bp_addr       (bp_addr),
      .max_cycles    (max_cycles),
      .pc            (pc),
      .instruction   (instruction),
      .commit_en     (commit_en),
      .running       (running),
      .halted        (halted),
      .halt_cause    (halt_cause),
      .retired_count (retired_count),
      .cycle_count   (cycle_count)
   );

   // Minimal datapath model: PC advances only on committed cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= 64'd0;
      else if (commit_en) pc <= pc + 64'd4;
   end

   assign instruction = imem[pc[5:2]];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare every commit and every entry into HALTED.
   always @(negedge clk) begin
      if (rst_n) begin
         if (commit_en) begin
            if (pcq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_commit: got pc %0h expected no commit", pc);
            end else begin
               chk("commit_pc", pc, pcq.pop_front());
            end
         end
         if (halted && !halted_prev) begin
            if (hq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_halt: got cause %0d expected no halt", halt_cause);
            end else begin
               halt_exp_t e;
               e = hq.pop_front();
               chk("halt_cause", 64'(halt_cause), 64'(e.cause));
               chk("halt_retired", retired_count, e.retired);
               chk("halt_cycles", 64'(cycle_count), 64'(e.cyc));
            end
         end
      end
      halted_prev <= halted;
   end

   task automatic push_halt(input logic [2:0] c, input logic [63:0] r, input logic [31:0] n);
      halt_exp_t e;
      e.cause = c; e.retired = r; e.cyc = n;
      hq.push_back(e);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic pulse_step();
      @(posedge clk); #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
   endtask

   task automatic wait_halted(input string name, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!halted) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got halted=0 expected halted=1 within %0d cycles", name, budget);
      end
      settle(2);
   endtask

   task automatic queues_empty(input string name);
      chk({name, "_pcq"}, 64'(pcq.size()), 64'd0);
      chk({name, "_hq"}, 64'(hq.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0; step = 1'b0; halt_req = 1'b0;
      bp_en = 1'b0; bp_addr = 64'd0; max_cycles = 32'd0;
      for (int i = 0; i < 16; i++) imem[i] = NOP;
      settle(2);
      rst_n = 1'b1;
      settle(1);
      chk("rst_commit_en", 64'(commit_en), 64'd0);
      chk("rst_running", 64'(running), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_cause", 64'(halt_cause), 64'd0);
      chk("rst_retired", retired_count, 64'd0);
      chk("rst_cycles", 64'(cycle_count), 64'd0);
   endtask

   initial begin
      halted_prev = 1'b0;

      // 1: cycle limit of 5 over NOPs
      do_reset();
      max_cycles = 32'd5;
      for (int i = 0; i < 5; i++) pcq.push_back(64'(i * 4));
      push_halt(3'd3, 64'd5, 32'd5);
      pulse_start();
      wait_halted("limit", 40);
      settle(3);
      queues_empty("t1");

      // 2: breakpoint at 0x10, then resume past it to an EBREAK at 0x18
      do_reset();
      bp_en = 1'b1; bp_addr = 64'h10;
      imem[6] = EBREAK;
      for (int i = 0; i < 4; i++) pcq.push_back(64'(i * 4));
      push_halt(3'd2, 64'd4, 32'd4);
      pulse_start();
      wait_halted("bp", 40);
      chk("bp_pc_held", pc, 64'h10);
      pcq.push_back(64'h10); pcq.push_back(64'h14); pcq.push_back(64'h18);
      push_halt(3'd5, 64'd7, 32'd2);
      pulse_start();
      wait_halted("bp_resume", 40);
      settle(2);
      queues_empty("t2");

      // 3: EBREAK at 0x8 retires then halts
      do_reset();
      imem[2] = EBREAK;
      pcq.push_back(64'h0); pcq.push_back(64'h4); pcq.push_back(64'h8);
      push_halt(3'd5, 64'd3, 32'd2);
      pulse_start();
      wait_halted("ebreak", 40);
      queues_empty("t3");

      // 4: single steps from HALTED
      pcq.push_back(64'hC);
      push_halt(3'd6, 64'd4, 32'd2);
      pulse_step();
      wait_halted("step", 10);
      halt_req = 1'b1;
      push_halt(3'd1, 64'd4, 32'd2);
      pulse_step();
      wait_halted("step_host", 10);
      halt_req = 1'b0;
      chk("step_host_pc", pc, 64'h10);
      imem[4] = ECALL;
      pcq.push_back(64'h10);
      push_halt(3'd4, 64'd5, 32'd2);
      pulse_step();
      wait_halted("step_ecall", 10);
      queues_empty("t4");

      // 5: start+step together -> RUN; start during RUN ignored
      do_reset();
      max_cycles = 32'd3;
      pcq.push_back(64'h0); pcq.push_back(64'h4); pcq.push_back(64'h8);
      push_halt(3'd3, 64'd3, 32'd3);
      @(posedge clk); #1 start = 1'b1; step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      chk("both_running", 64'(running), 64'd1);
      @(posedge clk); #1 start = 1'b0;
      wait_halted("start_in_run", 40);
      queues_empty("t5");

      // 6: asynchronous reset in the middle of RUN
      do_reset();
      pcq.push_back(64'h0); pcq.push_back(64'h4); pcq.push_back(64'h8);
      pulse_start();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #2;
      chk("mid_retired", retired_count, 64'd2);
      chk("mid_running", 64'(running), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_commit_en", 64'(commit_en), 64'd0);
      chk("arst_running", 64'(running), 64'd0);
      chk("arst_retired", retired_count, 64'd0);
      chk("arst_cycles", 64'(cycle_count), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      settle(2);
      chk("post_running", 64'(running), 64'd0);
      chk("post_halted", 64'(halted), 64'd0);
      chk("post_commit_en", 64'(commit_en), 64'd0);
      chk("post_cause", 64'(halt_cause), 64'd0);
      queues_empty("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
